// File: rtl/sc_branch_eval.sv
// SPARC Bicc branch evaluator: condition decode, target computation, delay-slot tracking and PC redirect.
// Optional statistics counters are enabled by defining SC_BRANCH_EVAL_STATS_EN.
module sc_branch_eval #(
    parameter int DATAWIDTH_PC    = 32,
    parameter int DATAWIDTH_DISP  = 22,
    parameter int DATAWIDTH_FLAGS = 4,
    parameter int STATS_WIDTH     = 16
) (
    input  logic                       SC_BranchEval_CLOCK_50,
    input  logic                       SC_BranchEval_RESET_InHigh,
    input  logic [DATAWIDTH_FLAGS-1:0] SC_BranchEval_Flags,
    input  logic                       SC_BranchEval_Branch,
    input  logic [3:0]                 SC_BranchEval_Cond,
    input  logic                       SC_BranchEval_AnnulBit,
    input  logic [DATAWIDTH_DISP-1:0]  SC_BranchEval_Disp,
    input  logic [DATAWIDTH_PC-1:0]    SC_BranchEval_PC,
    input  logic                       SC_BranchEval_Advance,
    output logic                       SC_BranchEval_Taken,
    output logic [DATAWIDTH_PC-1:0]    SC_BranchEval_Target,
    output logic                       SC_BranchEval_AnnulSlot,
    output logic                       SC_BranchEval_Redirect,
    output logic                       SC_BranchEval_Busy,
    output logic                       SC_BranchEval_Error
`ifdef SC_BRANCH_EVAL_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]     SC_BranchEval_TakenCount,
    output logic [STATS_WIDTH-1:0]     SC_BranchEval_NotTakenCount
`endif
);

    localparam int EXT_W = DATAWIDTH_PC - DATAWIDTH_DISP;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    taken_q, taken_d;
    logic [DATAWIDTH_PC-1:0] target_q, target_d;
    logic                    annul_q, annul_d;
    logic                    redirect_q, redirect_d;
    logic                    busy_q, busy_d;
    logic                    error_q, error_d;

    logic                    cond_s;
    logic                    capture_s;
    logic [DATAWIDTH_PC-1:0] disp_ext_s;
    logic [DATAWIDTH_PC-1:0] offset_s;
    logic [DATAWIDTH_PC-1:0] target_s;

    // Flags are packed {N,Z,V,C}; the upper half of the cond space is the complement of the lower half.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, v, c, base;
        n = flags[3];
        z = flags[2];
        v = flags[1];
        c = flags[0];
        case (cond[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = c | z;
            3'd5:    base = c;
            3'd6:    base = n;
            3'd7:    base = v;
            default: base = 1'b0;
        endcase
        return cond[3] ? ~base : base;
    endfunction

    assign cond_s     = eval_cond(SC_BranchEval_Cond, SC_BranchEval_Flags[3:0]);
    assign disp_ext_s = {{EXT_W{SC_BranchEval_Disp[DATAWIDTH_DISP-1]}}, SC_BranchEval_Disp};
    assign offset_s   = {disp_ext_s[DATAWIDTH_PC-3:0], 2'b00};
    assign target_s   = SC_BranchEval_PC + offset_s;
    assign capture_s  = (state_q == ST_IDLE) && SC_BranchEval_Branch;

    // Next-state and registered-output logic for the delay-slot FSM.
    always_comb begin
        state_d    = state_q;
        taken_d    = taken_q;
        target_d   = target_q;
        annul_d    = annul_q;
        redirect_d = 1'b0;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                // Advance in this cycle belongs to the branch itself, so it does not end a slot.
                if (SC_BranchEval_Branch) begin
                    taken_d  = cond_s;
                    target_d = target_s;
                    annul_d  = SC_BranchEval_AnnulBit & (~cond_s | (SC_BranchEval_Cond == 4'b1000));
                    state_d  = ST_SLOT;
                end else begin
                    annul_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_SLOT: begin
                if (SC_BranchEval_Branch) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                if (SC_BranchEval_Advance) begin
                    redirect_d = taken_q;
                    annul_d    = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_SLOT;
                end
            end
            default: begin
                annul_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SLOT);
    end

    // State and output registers.
    always_ff @(posedge SC_BranchEval_CLOCK_50 or posedge SC_BranchEval_RESET_InHigh) begin
        if (SC_BranchEval_RESET_InHigh) begin
            state_q    <= ST_IDLE;
            taken_q    <= 1'b0;
            target_q   <= {DATAWIDTH_PC{1'b0}};
            annul_q    <= 1'b0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
            annul_q    <= annul_d;
            redirect_q <= redirect_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign SC_BranchEval_Taken     = taken_q;
    assign SC_BranchEval_Target    = target_q;
    assign SC_BranchEval_AnnulSlot = annul_q;
    assign SC_BranchEval_Redirect  = redirect_q;
    assign SC_BranchEval_Busy      = busy_q;
    assign SC_BranchEval_Error     = error_q;

`ifdef SC_BRANCH_EVAL_STATS_EN
    logic [STATS_WIDTH-1:0] tcount_q;
    logic [STATS_WIDTH-1:0] ncount_q;

    // Saturating per-decision branch counters, cleared only by reset.
    always_ff @(posedge SC_BranchEval_CLOCK_50 or posedge SC_BranchEval_RESET_InHigh) begin
        if (SC_BranchEval_RESET_InHigh) begin
            tcount_q <= {STATS_WIDTH{1'b0}};
            ncount_q <= {STATS_WIDTH{1'b0}};
        end else begin
            if (capture_s && cond_s && (tcount_q != {STATS_WIDTH{1'b1}})) begin
                tcount_q <= tcount_q + {{(STATS_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                tcount_q <= tcount_q;
            end
            if (capture_s && !cond_s && (ncount_q != {STATS_WIDTH{1'b1}})) begin
                ncount_q <= ncount_q + {{(STATS_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                ncount_q <= ncount_q;
            end
        end
    end

    assign SC_BranchEval_TakenCount    = tcount_q;
    assign SC_BranchEval_NotTakenCount = ncount_q;
`else
    logic unused_capture_s;
    assign unused_capture_s = capture_s;
`endif

endmodule

// File: tb/tb_sc_branch_eval.sv
// Scoreboard bench for sc_branch_eval: directed Bicc vectors, delay-slot timing, error and reset cases.
module tb_sc_branch_eval;

`ifdef SC_BRANCH_EVAL_STATS_EN
    localparam int SW = 2;
`else
    localparam int SW = 16;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  flags;
    logic        branch;
    logic [3:0]  cond;
    logic        abit;
    logic [21:0] disp;
    logic [31:0] pc;
    logic        advance;
    logic        taken;
    logic [31:0] target;
    logic        annul_slot;
    logic        redirect;
    logic        busy;
    logic        error;
`ifdef SC_BRANCH_EVAL_STATS_EN
    logic [SW-1:0] tcount;
    logic [SW-1:0] ncount;
`endif

    int checks = 0;
    int errors = 0;

    logic [33:0] exp_cap[$];
    logic        exp_redir[$];
    logic        busy_prev = 1'b0;

    sc_branch_eval #(.STATS_WIDTH(SW)) dut (
        .SC_BranchEval_CLOCK_50     (clk),
        .SC_BranchEval_RESET_InHigh (rst),
        .SC_BranchEval_Flags        (flags),
        .SC_BranchEval_Branch       (branch),
        .SC_BranchEval_Cond         (cond),
        .SC_BranchEval_AnnulBit     (abit),
        .SC_BranchEval_Disp         (disp),
        .SC_BranchEval_PC           (pc),
        .SC_BranchEval_Advance      (advance),
        .SC_BranchEval_Taken        (taken),
        .SC_BranchEval_Target       (target),
        .SC_BranchEval_AnnulSlot    (annul_slot),
        .SC_BranchEval_Redirect     (redirect),
        .SC_BranchEval_Busy         (busy),
        .SC_BranchEval_Error        (error)
`ifdef SC_BRANCH_EVAL_STATS_EN
        ,
        .SC_BranchEval_TakenCount   (tcount),
        .SC_BranchEval_NotTakenCount(ncount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: slot entry presents the decision, slot exit presents the redirect.
    always @(negedge clk) begin
        logic [33:0] e;
        logic        r;
        if (busy && !busy_prev) begin
            if (exp_cap.size() == 0) begin
                chk("unexpected_capture", 32'd1, 32'd0);
            end else begin
                e = exp_cap.pop_front();
                chk("taken", {31'd0, taken}, {31'd0, e[33]});
                chk("annul_slot", {31'd0, annul_slot}, {31'd0, e[32]});
                chk("target", target, e[31:0]);
            end
        end
        if (!busy && busy_prev) begin
            if (exp_redir.size() == 0) begin
                chk("unexpected_slot_end", 32'd1, 32'd0);
            end else begin
                r = exp_redir.pop_front();
                chk("redirect", {31'd0, redirect}, {31'd0, r});
            end
        end else if (redirect) begin
            chk("spurious_redirect", {31'd0, redirect}, 32'd0);
        end
        busy_prev <= busy;
    end

    task automatic push_exp(input logic et, input logic ea, input logic [31:0] etgt, input logic er);
        exp_cap.push_back({et, ea, etgt});
        exp_redir.push_back(er);
    endtask

    // Branch, one idle slot cycle with scrambled flags, then the slot retires.
    task automatic slow_branch(input logic [3:0] f, input logic [3:0] c, input logic a,
                               input logic [31:0] p, input logic [21:0] d,
                               input logic et, input logic [31:0] etgt, input logic ea);
        flags = f; cond = c; abit = a; pc = p; disp = d; branch = 1'b1; advance = 1'b0;
        push_exp(et, ea, etgt, et);
        @(posedge clk); #1;
        branch = 1'b0; flags = ~f;
        @(posedge clk); #1;
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0;
    endtask

    // Branch with Advance held high: minimum latency path.
    task automatic fast_branch(input logic [3:0] f, input logic [3:0] c, input logic a,
                               input logic [31:0] p, input logic [21:0] d,
                               input logic et, input logic [31:0] etgt, input logic ea);
        flags = f; cond = c; abit = a; pc = p; disp = d; branch = 1'b1; advance = 1'b1;
        push_exp(et, ea, etgt, et);
        @(posedge clk); #1;
        branch = 1'b0;
        @(posedge clk); #1;
        advance = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flags = 4'h0; branch = 1'b0; cond = 4'h0; abit = 1'b0;
        disp = 22'h0; pc = 32'h0; advance = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        slow_branch(4'b0100, 4'b0001, 1'b0, 32'h0000_0100, 22'h000004, 1'b1, 32'h0000_0110, 1'b0);
        slow_branch(4'b0100, 4'b1001, 1'b1, 32'h0000_0200, 22'h000010, 1'b0, 32'h0000_0240, 1'b1);
`ifdef SC_BRANCH_EVAL_STATS_EN
        chk("tcount_1", {30'd0, tcount}, 32'd1);
        chk("ncount_1", {30'd0, ncount}, 32'd1);
`endif
        slow_branch(4'b0000, 4'b1000, 1'b1, 32'h0000_0010, 22'h3FFFFF, 1'b1, 32'h0000_000C, 1'b1);
        slow_branch(4'b0000, 4'b1000, 1'b0, 32'h0000_0000, 22'h3FFFFE, 1'b1, 32'hFFFF_FFF8, 1'b0);
        slow_branch(4'b1000, 4'b0010, 1'b1, 32'h0000_1000, 22'h200000, 1'b1, 32'hFF80_1000, 1'b0);
        slow_branch(4'b0001, 4'b0101, 1'b1, 32'hFFFF_FFF0, 22'h000008, 1'b1, 32'h0000_0010, 1'b0);
        slow_branch(4'b0001, 4'b1101, 1'b0, 32'h0000_0040, 22'h000001, 1'b0, 32'h0000_0044, 1'b0);
        slow_branch(4'b0000, 4'b0000, 1'b1, 32'h0000_0080, 22'h000000, 1'b0, 32'h0000_0080, 1'b1);
        slow_branch(4'b0010, 4'b0111, 1'b0, 32'h0000_0000, 22'h000100, 1'b1, 32'h0000_0400, 1'b0);
        slow_branch(4'b1010, 4'b1011, 1'b1, 32'h0000_0008, 22'h000002, 1'b1, 32'h0000_0010, 1'b0);
        slow_branch(4'b0000, 4'b0100, 1'b1, 32'h0000_0020, 22'h000003, 1'b0, 32'h0000_002C, 1'b1);
        fast_branch(4'b0000, 4'b1100, 1'b0, 32'h0000_0600, 22'h000004, 1'b1, 32'h0000_0610, 1'b0);
        fast_branch(4'b1000, 4'b0110, 1'b1, 32'h0000_0700, 22'h3FFFFC, 1'b1, 32'h0000_06F0, 1'b0);
`ifdef SC_BRANCH_EVAL_STATS_EN
        chk("tcount_sat", {30'd0, tcount}, 32'd3);
        chk("ncount_sat", {30'd0, ncount}, 32'd3);
`endif

        // Branch inside the slot raises a sticky error; the frozen decision ignores new flags.
        chk("error_before", {31'd0, error}, 32'd0);
        flags = 4'b0000; cond = 4'b1000; abit = 1'b0; pc = 32'h0000_0300; disp = 22'h000001;
        branch = 1'b1; advance = 1'b0;
        push_exp(1'b1, 1'b0, 32'h0000_0304, 1'b1);
        @(posedge clk); #1;
        cond = 4'b0000; flags = 4'b1111; pc = 32'h0000_0900;
        @(posedge clk); #1;
        branch = 1'b0;
        chk("error_set", {31'd0, error}, 32'd1);
        chk("slot_held", {31'd0, busy}, 32'd1);
        chk("taken_frozen", {31'd0, taken}, 32'd1);
        chk("target_frozen", target, 32'h0000_0304);
        @(posedge clk); #1;
        chk("error_sticky", {31'd0, error}, 32'd1);
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0;
        @(posedge clk); #1;
        chk("error_after_slot", {31'd0, error}, 32'd1);

        // Reset in the middle of a slot abandons it without a redirect.
        flags = 4'b0000; cond = 4'b1000; abit = 1'b1; pc = 32'h0000_0500; disp = 22'h000002;
        branch = 1'b1;
        push_exp(1'b1, 1'b1, 32'h0000_0508, 1'b0);
        @(posedge clk); #1;
        branch = 1'b0;
        @(posedge clk); #1;
        advance = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_taken", {31'd0, taken}, 32'd0);
        chk("mid_rst_target", target, 32'd0);
        chk("mid_rst_annul", {31'd0, annul_slot}, 32'd0);
        chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("mid_rst_error", {31'd0, error}, 32'd0);
`ifdef SC_BRANCH_EVAL_STATS_EN
        chk("mid_rst_tcount", {30'd0, tcount}, 32'd0);
        chk("mid_rst_ncount", {30'd0, ncount}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        advance = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("cap_queue_empty", exp_cap.size(), 32'd0);
        chk("redir_queue_empty", exp_redir.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
